// File: rtl/wb_charlieplex_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_charlieplex_if : Wishbone classic slave bundle for wb_charlieplex
// Rev 1.0
// ---------------------------------------------------------------------------
interface wb_charlieplex_if #(
  parameter int ADDR_W = 6
);
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_adr_i;
  logic [7:0]        wb_dat_i;
  logic [7:0]        wb_dat_o;
  logic              wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_charlieplex.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_charlieplex : Wishbone charlieplexed LED driver with per-LED PWM.
// Option macro CHARLIE_READBACK_EN enables framebuffer readback.   Rev 1.0
// ---------------------------------------------------------------------------
module wb_charlieplex #(
  parameter int PINS           = 7,
  parameter int BRIGHT_W       = 4,
  parameter int TICKS_PER_STEP = 4,
  parameter int DEAD_CYCLES    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_charlieplex_if.slave wb,
  output logic [PINS-1:0] charlie_o,
  output logic [PINS-1:0] charlie_oe
);
  localparam int ADDR_W = $clog2(PINS*PINS+1);
  localparam int AW     = $clog2(PINS);
  localparam int PW     = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int DW     = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [ADDR_W-1:0]   CTRL_ADDR  = ADDR_W'(PINS*PINS);
  localparam logic [BRIGHT_W-1:0] PWM_LAST   = BRIGHT_W'((1 << BRIGHT_W) - 2);
  localparam logic [PW-1:0]       PRESC_LAST = PW'(TICKS_PER_STEP - 1);
  localparam logic [DW-1:0]       DEAD_LAST  = DW'(DEAD_CYCLES - 1);
  localparam logic [AW-1:0]       ANODE_LAST = AW'(PINS - 1);

  typedef enum logic [0:0] {
    ST_DEAD = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  logic                ack_q;
  logic [7:0]          dat_q;
  logic                en_q;
  logic [BRIGHT_W-1:0] fb_q [PINS][PINS];

  state_e              state_q;
  logic [AW-1:0]       anode_q;
  logic [BRIGHT_W-1:0] pwm_q;
  logic [PW-1:0]       presc_q;
  logic [DW-1:0]       dead_q;
  logic [PINS-1:0]     o_q, oe_q;
  logic [PINS-1:0]     o_d, oe_d;

  logic       req_d;
  logic       wr_d;
  logic [7:0] rd_d;
  logic       unused_dat;

  assign req_d      = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr_d       = req_d & wb.wb_we_i;
  assign unused_dat = ^wb.wb_dat_i;

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign charlie_o   = o_q;
  assign charlie_oe  = oe_q;

  always_comb begin
    rd_d = 8'h00;
    if (wb.wb_adr_i == CTRL_ADDR) rd_d = {7'b0, en_q};
`ifdef CHARLIE_READBACK_EN
    for (int a = 0; a < PINS; a++) begin
      for (int k = 0; k < PINS; k++) begin
        if (wb.wb_adr_i == ADDR_W'(a*PINS + k)) rd_d = 8'(fb_q[a][k]);
      end
    end
`endif
  end

  // Diagonal cells are never written, so they stay 0 and read back as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      dat_q <= 8'h00;
      en_q  <= 1'b0;
      for (int a = 0; a < PINS; a++) begin
        for (int k = 0; k < PINS; k++) fb_q[a][k] <= '0;
      end
    end else begin
      ack_q <= req_d;
      dat_q <= req_d ? rd_d : 8'h00;
      if (wr_d && (wb.wb_adr_i == CTRL_ADDR)) en_q <= wb.wb_dat_i[0];
      for (int a = 0; a < PINS; a++) begin
        for (int k = 0; k < PINS; k++) begin
          if ((a != k) && wr_d && (wb.wb_adr_i == ADDR_W'(a*PINS + k)))
            fb_q[a][k] <= wb.wb_dat_i[BRIGHT_W-1:0];
        end
      end
    end
  end

  always_comb begin
    o_d  = '0;
    oe_d = '0;
    if (state_q == ST_SCAN) begin
      for (int k = 0; k < PINS; k++) begin
        if (anode_q == AW'(k)) begin
          o_d[k]  = 1'b1;
          oe_d[k] = 1'b1;
        end else begin
          oe_d[k] = (pwm_q < fb_q[anode_q][k]);
        end
      end
    end
  end

  // Outputs are gated by the current enable so a disable blanks the pins on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DEAD;
      anode_q <= '0;
      pwm_q   <= '0;
      presc_q <= '0;
      dead_q  <= '0;
      o_q     <= '0;
      oe_q    <= '0;
    end else if (!en_q) begin
      state_q <= ST_DEAD;
      anode_q <= '0;
      pwm_q   <= '0;
      presc_q <= '0;
      dead_q  <= '0;
      o_q     <= '0;
      oe_q    <= '0;
    end else begin
      o_q  <= o_d;
      oe_q <= oe_d;
      case (state_q)
        ST_DEAD: begin
          if (dead_q == DEAD_LAST) begin
            state_q <= ST_SCAN;
            presc_q <= '0;
            pwm_q   <= '0;
          end else begin
            dead_q <= dead_q + 1'b1;
          end
        end
        ST_SCAN: begin
          if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            if (pwm_q == PWM_LAST) begin
              pwm_q   <= '0;
              dead_q  <= '0;
              state_q <= ST_DEAD;
              anode_q <= (anode_q == ANODE_LAST) ? '0 : anode_q + 1'b1;
            end else begin
              pwm_q <= pwm_q + 1'b1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        default: state_q <= ST_DEAD;
      endcase
    end
  end
endmodule
`default_nettype wire
